// File: rtl/mult_seq.sv
// Multi-cycle shift-and-add multiplier feeding HI/LO (MULT/MULTU).
// Optional signed support is enabled by defining MULT_SEQ_SIGNED_EN.
module mult_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [N-1:0]    a_op, b_op;
  logic [N-1:0]    addend;
  logic [N:0]      sum;
  logic [2*N-1:0]  prod;

`ifdef MULT_SEQ_SIGNED_EN
  logic            neg_q, neg_d;
`else
  logic            unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    a_op    = a;
    b_op    = b;
    addend  = '0;
    sum     = '0;
    prod    = acc_q;
`ifdef MULT_SEQ_SIGNED_EN
    neg_d   = neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULT_SEQ_SIGNED_EN
          // Magnitudes are taken as unsigned N-bit values, so the most
          // negative operand maps to 2^(N-1) without overflow.
          if (is_signed) begin
            a_op  = a[N-1] ? (-a) : a;
            b_op  = b[N-1] ? (-b) : b;
            neg_d = a[N-1] ^ b[N-1];
          end else begin
            neg_d = 1'b0;
          end
`endif
          acc_d   = {{N{1'b0}}, b_op};
          mcand_d = a_op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        addend = acc_q[0] ? mcand_q : '0;
        sum    = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};
        // Carry-out lands in the top bit as the accumulator shifts right.
        acc_d  = {sum, acc_q[N-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
`ifdef MULT_SEQ_SIGNED_EN
        if (neg_q) begin
          prod = -acc_q;
        end
`endif
        {hi_d, lo_d} = prod;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
